pic_ctrl: RTL and testbench

//  Clocked, parametrised programmable interrupt controller; successor to the 8259-style PIC.

---
 rtl/pic_pkg.sv | 34 +++
 rtl/pic_prio_resolver.sv | 43 ++++
 rtl/pic_ctrl.sv | 179 +++++++++++++++++
 tb/tb_pic_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared constants, FSM encoding and helpers for the programmable interrupt controller.
// The controller's register map, OCW2/OCW3 command encodings and INTA sequence states are defined here.
package pic_pkg;

   localparam logic [1:0] PIC_CMD   = 2'd0;
   localparam logic [1:0] PIC_IMR   = 2'd1;
   localparam logic [1:0] PIC_ELCR  = 2'd2;
   localparam logic [1:0] PIC_VBASE = 2'd3;

   localparam logic [1:0] OCW_SEL_OCW2 = 2'b00;
   localparam logic [1:0] OCW_SEL_OCW3 = 2'b01;

   localparam logic [2:0] OCW2_NS_EOI  = 3'b001;
   localparam logic [2:0] OCW2_SP_EOI  = 3'b011;
   localparam logic [2:0] OCW2_ROT_EOI = 3'b101;

   localparam logic [1:0] OCW3_RD_IRR = 2'b10;
   localparam logic [1:0] OCW3_RD_ISR = 2'b11;

   localparam logic [7:0] VBASE_RST  = 8'h08;
   localparam logic [2:0] SPURIOUS_W = 3'd7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACK1 = 2'd1,
      ACK2 = 2'd2
   } pic_state_e;

   // Level index (v) folded into 0..n-1; v never reaches 2n.
   function automatic logic [2:0] lvl_wrap(input int v, input int n);
      return 3'((v >= n) ? v - n : v);
   endfunction

endpackage

// File: rtl/pic_prio_resolver.sv
// Rotating-priority encoder: finds the highest in-service level and the best pending request
// that is strictly higher in priority than it (fully nested mode).
module pic_prio_resolver import pic_pkg::*; #(
   parameter int N_IRQ = 8
) (
   input  logic [N_IRQ-1:0] pending,
   input  logic [N_IRQ-1:0] isr,
   input  logic [2:0]       pointer,
   output logic             valid,
   output logic [2:0]       winner,
   output logic             isr_valid,
   output logic [2:0]       isr_top
);

   int         isr_rank;
   logic [2:0] lvl;

   // Rank i is distance from the pointer; scanning downwards leaves the lowest rank as result.
   always_comb begin
      isr_valid = 1'b0;
      isr_top   = '0;
      isr_rank  = N_IRQ;
      valid     = 1'b0;
      winner    = '0;
      lvl       = '0;
      for (int i = N_IRQ - 1; i >= 0; i--) begin
         lvl = lvl_wrap(int'(pointer) + i, N_IRQ);
         if (isr[lvl]) begin
            isr_valid = 1'b1;
            isr_top   = lvl;
            isr_rank  = i;
         end
      end
      for (int i = N_IRQ - 1; i >= 0; i--) begin
         lvl = lvl_wrap(int'(pointer) + i, N_IRQ);
         if (pending[lvl] && (i < isr_rank)) begin
            valid  = 1'b1;
            winner = lvl;
         end
      end
   end

endmodule

// File: rtl/pic_ctrl.sv
// Programmable interrupt controller: input synchronisers, strobe edge detectors, IRR/ISR/IMR/ELCR/VBASE
// registers, and the two-pulse INTA sequencer that hands the CPU its vector.
module pic_ctrl import pic_pkg::*; #(
   parameter int N_IRQ = 8,
   parameter bit AEOI  = 1'b0,
   parameter int SYNC  = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cs_n,
   input  logic             wr_n,
   input  logic             rd_n,
   input  logic [1:0]       addr,
   input  logic [7:0]       din,
   output logic [7:0]       dout,
   output logic             dout_oe,
   input  logic [N_IRQ-1:0] ir,
   output logic             intr,
   input  logic             inta_n,
   output logic [1:0]       dbg_state
);

   // Bus handshake: a write is one action per wr_n falling edge while cs_n is low; address and data
   // are taken on the clock that detects the edge. Reads are combinational while cs_n and rd_n are low.
   logic [N_IRQ-1:0] sync_q [SYNC];
   logic [N_IRQ-1:0] ir_s, ir_d, ir_rise;
   logic             wr_q, inta_q, wr_fall, inta_fall, inta_rise, wr_go, cmd_wr;
   logic [N_IRQ-1:0] irr, irr_n, isr, isr_n, imr, elcr, pending;
   logic [4:0]       vbase;
   logic [2:0]       ptr, ptr_n, w, w_n, win, isr_top;
   logic             spur, spur_n, rdsel_isr, intr_n, pend_valid, isr_valid;
   logic [7:0]       rd_word;
   pic_state_e       state, state_n;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < SYNC; k++) sync_q[k] <= '0;
         ir_d   <= '0;
         wr_q   <= 1'b1;
         inta_q <= 1'b1;
      end else begin
         sync_q[0] <= ir;
         for (int k = 1; k < SYNC; k++) sync_q[k] <= sync_q[k-1];
         ir_d   <= ir_s;
         wr_q   <= wr_n;
         inta_q <= inta_n;
      end
   end

   assign ir_s      = sync_q[SYNC-1];
   assign ir_rise   = ir_s & ~ir_d;
   assign wr_fall   = wr_q & ~wr_n;
   assign inta_fall = inta_q & ~inta_n;
   assign inta_rise = ~inta_q & inta_n;
   assign wr_go     = wr_fall & ~cs_n;
   assign cmd_wr    = wr_go && (addr == PIC_CMD) && (din[4:3] == OCW_SEL_OCW2);
   assign pending   = irr & ~imr;
   assign dbg_state = state;

   pic_prio_resolver #(.N_IRQ(N_IRQ)) u_prio (
      .pending   (pending),
      .isr       (isr),
      .pointer   (ptr),
      .valid     (pend_valid),
      .winner    (win),
      .isr_valid (isr_valid),
      .isr_top   (isr_top)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         irr       <= '0;
         isr       <= '0;
         ptr       <= '0;
         w         <= '0;
         spur      <= 1'b0;
         intr      <= 1'b0;
         imr       <= '1;
         elcr      <= '0;
         vbase     <= VBASE_RST[7:3];
         rdsel_isr <= 1'b0;
      end else begin
         state <= state_n;
         irr   <= irr_n;
         isr   <= isr_n;
         ptr   <= ptr_n;
         w     <= w_n;
         spur  <= spur_n;
         intr  <= intr_n;
         if (wr_go) begin
            case (addr)
               PIC_IMR:   imr   <= din[N_IRQ-1:0];
               PIC_ELCR:  elcr  <= din[N_IRQ-1:0];
               PIC_VBASE: vbase <= din[7:3];
               default: begin
                  if (din[4:3] == OCW_SEL_OCW3) begin
                     if (din[1:0] == OCW3_RD_IRR) rdsel_isr <= 1'b0;
                     else if (din[1:0] == OCW3_RD_ISR) rdsel_isr <= 1'b1;
                  end
               end
            endcase
         end
      end
   end

   // EOI is applied before the ACK1 set, so a same-cycle EOI cannot clear the newly serviced level.
   always_comb begin
      state_n = state;
      w_n     = w;
      spur_n  = spur;
      isr_n   = isr;
      ptr_n   = ptr;
      intr_n  = 1'b0;
      for (int i = 0; i < N_IRQ; i++)
         irr_n[i] = elcr[i] ? ir_s[i] : (irr[i] | ir_rise[i]);
      if (cmd_wr) begin
         case (din[7:5])
            OCW2_NS_EOI:  if (isr_valid) isr_n[isr_top] = 1'b0;
            OCW2_SP_EOI:  if (int'(din[2:0]) < N_IRQ) isr_n[din[2:0]] = 1'b0;
            OCW2_ROT_EOI: if (isr_valid) begin
                             isr_n[isr_top] = 1'b0;
                             ptr_n = lvl_wrap(int'(isr_top) + 1, N_IRQ);
                          end
            default: ;
         endcase
      end
      case (state)
         IDLE: begin
            intr_n = pend_valid;
            if (inta_fall) begin
               state_n = ACK1;
               intr_n  = 1'b0;
               if (intr && pend_valid) begin
                  w_n         = win;
                  spur_n      = 1'b0;
                  isr_n[win]  = 1'b1;
                  if (!elcr[win]) irr_n[win] = 1'b0;
               end else begin
                  w_n    = SPURIOUS_W;
                  spur_n = 1'b1;
               end
            end
         end
         ACK1: begin
            if (inta_fall) begin
               state_n = ACK2;
               // Auto-EOI always rotates so the just-serviced level drops to lowest priority.
               if (AEOI && !spur) begin
                  isr_n[w] = 1'b0;
                  ptr_n    = lvl_wrap(int'(w) + 1, N_IRQ);
               end
            end
         end
         ACK2: if (inta_rise) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      rd_word = '0;
      dout    = '0;
      dout_oe = 1'b0;
      case (addr)
         PIC_CMD:   rd_word[N_IRQ-1:0] = rdsel_isr ? isr : irr;
         PIC_IMR:   rd_word[N_IRQ-1:0] = imr;
         PIC_ELCR:  rd_word[N_IRQ-1:0] = elcr;
         default:   rd_word = {vbase, 3'b000};
      endcase
      if ((state == ACK2) && !inta_n) begin
         dout    = {vbase, w};
         dout_oe = 1'b1;
      end else if (!cs_n && !rd_n) begin
         dout    = rd_word;
         dout_oe = 1'b1;
      end
   end

endmodule

// File: tb/tb_pic_ctrl.sv
// Directed bench for pic_ctrl: bus register access, nested priority, level/edge triggers,
// rotation, masking, spurious cycles and reset in the middle of an INTA sequence.
module tb_pic_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cs_n = 1'b1, wr_n = 1'b1, rd_n = 1'b1, inta_n = 1'b1;
   logic [1:0] addr = '0;
   logic [7:0] din = '0;
   logic [7:0] ir = '0;
   logic [7:0] dout;
   logic       dout_oe, intr;
   logic [1:0] dbg_state;

   int n_cmp = 0;
   int n_err = 0;
   logic [7:0] exp_q[$];

   pic_ctrl #(.N_IRQ(8), .AEOI(1'b0), .SYNC(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .cs_n      (cs_n),
      .wr_n      (wr_n),
      .rd_n      (rd_n),
      .addr      (addr),
      .din       (din),
      .dout      (dout),
      .dout_oe   (dout_oe),
      .ir        (ir),
      .intr      (intr),
      .inta_n    (inta_n),
      .dbg_state (dbg_state)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (n_cmp=%0d)", n_cmp);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // driver tasks
   task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
      @(negedge clk);
      cs_n = 1'b0; addr = a; din = d; wr_n = 1'b0;
      @(negedge clk);
      wr_n = 1'b1; cs_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic read_check(input logic [1:0] a, input logic [7:0] exp, input string tag);
      logic [7:0] d;
      @(negedge clk);
      cs_n = 1'b0; rd_n = 1'b0; addr = a;
      #2;
      d = dout;
      check({tag, "_oe"}, {7'd0, dout_oe}, 8'h01);
      check(tag, d, exp);
      rd_n = 1'b1; cs_n = 1'b1;
   endtask

   task automatic read_isr(input logic [7:0] exp, input string tag);
      bus_write(2'd0, 8'h0B);
      read_check(2'd0, exp, tag);
   endtask

   task automatic read_irr(input logic [7:0] exp, input string tag);
      bus_write(2'd0, 8'h0A);
      read_check(2'd0, exp, tag);
   endtask

   task automatic wait_intr(input logic val, input int budget, input string tag);
      for (int n = 0; n < budget; n++) begin
         @(negedge clk);
         if (intr === val) break;
      end
      check(tag, {7'd0, intr}, {7'd0, val});
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic inta_pulse1(input string tag);
      @(negedge clk);
      inta_n = 1'b0;
      @(negedge clk);
      check({tag, "_intr_drop"}, {7'd0, intr}, 8'h00);
      check({tag, "_st_ack1"}, {6'd0, dbg_state}, 8'h01);
      inta_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic inta_pulse2(input string tag);
      logic [7:0] v;
      @(negedge clk);
      inta_n = 1'b0;
      @(negedge clk);
      #1;
      v = dout;
      check({tag, "_vec_oe"}, {7'd0, dout_oe}, 8'h01);
      if (exp_q.size() == 0) begin
         n_cmp++; n_err++;
         $display("FAIL %s_vec: got %h expected <none queued>", tag, v);
      end else begin
         check({tag, "_vec"}, v, exp_q.pop_front());
      end
      inta_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check({tag, "_st_idle"}, {6'd0, dbg_state}, 8'h00);
   endtask

   task automatic inta_ack(input string tag);
      inta_pulse1(tag);
      inta_pulse2(tag);
   endtask

   initial begin
      // 1: reset values and first edge-triggered request
      idle(3);
      check("rst_intr", {7'd0, intr}, 8'h00);
      check("rst_dout", dout, 8'h00);
      check("rst_oe", {7'd0, dout_oe}, 8'h00);
      check("rst_state", {6'd0, dbg_state}, 8'h00);
      @(negedge clk);
      rst = 1'b0;
      read_check(2'd1, 8'hFF, "rst_imr");
      read_check(2'd2, 8'h00, "rst_elcr");
      read_check(2'd3, 8'h08, "rst_vbase");
      read_check(2'd0, 8'h00, "rst_irr");
      bus_write(2'd1, 8'h00);
      @(negedge clk);
      ir[3] = 1'b1;
      wait_intr(1'b1, 4, "t1_intr");
      ir[3] = 1'b0;
      exp_q.push_back(8'h0B);
      inta_ack("t1");
      read_isr(8'h08, "t1_isr");
      read_irr(8'h00, "t1_irr");

      // 2: nesting under ISR[3]
      @(negedge clk);
      ir[5] = 1'b1;
      idle(6);
      check("t2_ir5_blocked", {7'd0, intr}, 8'h00);
      ir[5] = 1'b0;
      ir[1] = 1'b1;
      wait_intr(1'b1, 4, "t2_ir1_intr");
      ir[1] = 1'b0;
      exp_q.push_back(8'h09);
      inta_ack("t2a");
      read_isr(8'h0A, "t2_isr_nested");
      bus_write(2'd0, 8'h20);
      read_isr(8'h08, "t2_isr_eoi1");
      bus_write(2'd0, 8'h20);
      wait_intr(1'b1, 4, "t2_ir5_intr");
      exp_q.push_back(8'h0D);
      inta_ack("t2b");
      read_isr(8'h20, "t2_isr_ir5");
      bus_write(2'd0, 8'h20);
      read_isr(8'h00, "t2_isr_clear");

      // 3: level-triggered line and spurious cycle
      bus_write(2'd2, 8'h04);
      @(negedge clk);
      ir[2] = 1'b1;
      wait_intr(1'b1, 4, "t3_intr");
      exp_q.push_back(8'h0A);
      inta_ack("t3a");
      read_irr(8'h04, "t3_irr_level");
      check("t3_intr_blocked", {7'd0, intr}, 8'h00);
      bus_write(2'd0, 8'h20);
      wait_intr(1'b1, 4, "t3_intr_reassert");
      @(negedge clk);
      ir[2] = 1'b0;
      wait_intr(1'b0, 6, "t3_intr_gone");
      exp_q.push_back(8'h0F);
      inta_ack("t3_spur");
      read_isr(8'h00, "t3_isr_spur");

      // 4: vector base and rotate-on-EOI
      bus_write(2'd2, 8'h00);
      bus_write(2'd3, 8'h70);
      read_check(2'd3, 8'h70, "t4_vbase");
      @(negedge clk);
      ir[0] = 1'b1;
      wait_intr(1'b1, 4, "t4_ir0_intr");
      ir[0] = 1'b0;
      exp_q.push_back(8'h70);
      inta_ack("t4a");
      read_isr(8'h01, "t4_isr_ir0");
      bus_write(2'd0, 8'hA0);
      read_isr(8'h00, "t4_isr_rot");
      idle(4);
      ir[0] = 1'b1;
      ir[4] = 1'b1;
      wait_intr(1'b1, 4, "t4_both_intr");
      ir[0] = 1'b0;
      ir[4] = 1'b0;
      exp_q.push_back(8'h74);
      inta_ack("t4b");
      read_isr(8'h10, "t4_isr_ir4");
      bus_write(2'd0, 8'h20);
      wait_intr(1'b1, 4, "t4_ir0_again");
      exp_q.push_back(8'h70);
      inta_ack("t4c");
      bus_write(2'd0, 8'h20);
      read_isr(8'h00, "t4_isr_clear");

      // 5: masking, latched edge, specific EOI
      bus_write(2'd1, 8'h40);
      @(negedge clk);
      ir[6] = 1'b1;
      idle(6);
      check("t5_masked", {7'd0, intr}, 8'h00);
      ir[6] = 1'b0;
      read_irr(8'h40, "t5_irr_latched");
      bus_write(2'd1, 8'h00);
      wait_intr(1'b1, 4, "t5_unmask_intr");
      exp_q.push_back(8'h76);
      inta_ack("t5");
      read_isr(8'h40, "t5_isr");
      bus_write(2'd0, 8'h66);
      read_isr(8'h00, "t5_isr_sp_eoi");

      // 6: reset between the two INTA pulses
      @(negedge clk);
      ir[3] = 1'b1;
      wait_intr(1'b1, 4, "t6_intr");
      ir[3] = 1'b0;
      inta_pulse1("t6a");
      rst = 1'b1;
      #1;
      check("t6_rst_state", {6'd0, dbg_state}, 8'h00);
      check("t6_rst_intr", {7'd0, intr}, 8'h00);
      @(negedge clk);
      rst = 1'b0;
      read_check(2'd1, 8'hFF, "t6_imr");
      read_check(2'd3, 8'h08, "t6_vbase");
      read_isr(8'h00, "t6_isr");
      exp_q.push_back(8'h0F);
      inta_ack("t6b");
      read_isr(8'h00, "t6_isr_after");

      // final report
      if (exp_q.size() != 0) begin
         n_cmp++; n_err++;
         $display("FAIL exp_q_drain: got %0d left expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
